// File: rtl/hazard_unit_pkg.sv
// Shared encodings and helpers for the pipeline hazard unit.
// Holds forward-select codes, FSM states and the memory-wait timeout limit.
package hazard_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WAIT_CNT_W = 8;
    localparam int unsigned CNT_W      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    localparam wait_cnt_t TIMEOUT_LIMIT = 8'd255;

    typedef enum logic {
        StRun  = 1'b0,
        StWait = 1'b1
    } hz_state_e;

    // Memory stage wins over writeback because it holds the younger result.
    function automatic logic [1:0] fwd_select(
        input reg_addr_t rs,
        input reg_addr_t rd_m,
        input logic      wr_m,
        input reg_addr_t rd_w,
        input logic      wr_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wr_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_M;
        end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that increments on enable and sticks at all-ones.
module sat_counter32 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, redirect flushes, operand forwarding and
// data-memory wait handling with a sticky timeout flag and performance counters.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        ResultSrcE0,
    input  logic        PCSrcE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        DMemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        Flush_E,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount,
    output logic        MemTimeout
);

    reg_addr_t rs1_e_q, rs1_e_d;
    reg_addr_t rs2_e_q, rs2_e_d;
    reg_addr_t rd_e_q,  rd_e_d;
    reg_addr_t rd_m_q,  rd_m_d;
    reg_addr_t rd_w_q,  rd_w_d;

    hz_state_e state_q, state_d;
    wait_cnt_t wait_cnt_q, wait_cnt_d;
    logic      timeout_q, timeout_d;

    logic lw_stall;
    logic mem_wait;
    logic flush_any;

    always_comb begin
        lw_stall = ResultSrcE0 && (rd_e_q != '0) && ((rd_e_q == Rs1D) || (rd_e_q == Rs2D));
        mem_wait = !DMemReadyM;
    end

    // A memory wait freezes the whole front end; redirects and load-use are
    // deferred until the access completes so nothing is lost.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        Flush_E = 1'b0;
        FlushW  = 1'b0;
        if (mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF  = lw_stall;
            StallD  = lw_stall;
            FlushD  = PCSrcE;
            Flush_E = lw_stall | PCSrcE;
        end
    end

    always_comb begin
        ForwardAE = fwd_select(rs1_e_q, rd_m_q, RegWriteM, rd_w_q, RegWriteW);
        ForwardBE = fwd_select(rs2_e_q, rd_m_q, RegWriteM, rd_w_q, RegWriteW);
    end

    always_comb begin
        rs1_e_d = rs1_e_q;
        rs2_e_d = rs2_e_q;
        rd_e_d  = rd_e_q;
        rd_m_d  = rd_m_q;
        rd_w_d  = FlushW ? '0 : rd_m_q;
        if (Flush_E) begin
            rs1_e_d = '0;
            rs2_e_d = '0;
            rd_e_d  = '0;
        end else if (!StallE) begin
            rs1_e_d = Rs1D;
            rs2_e_d = Rs2D;
            rd_e_d  = RdD;
        end
        if (!StallM) begin
            rd_m_d = rd_e_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1_e_q <= '0;
            rs2_e_q <= '0;
            rd_e_q  <= '0;
            rd_m_q  <= '0;
            rd_w_q  <= '0;
        end else begin
            rs1_e_q <= rs1_e_d;
            rs2_e_q <= rs2_e_d;
            rd_e_q  <= rd_e_d;
            rd_m_q  <= rd_m_d;
            rd_w_q  <= rd_w_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        timeout_d  = timeout_q;
        unique case (state_q)
            StRun: begin
                if (mem_wait) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (DMemReadyM) begin
                    state_d = StRun;
                end else if (wait_cnt_q != TIMEOUT_LIMIT) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
        if (wait_cnt_d == TIMEOUT_LIMIT) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign MemTimeout = timeout_q;
    assign flush_any  = FlushD | Flush_E;

    sat_counter32 u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (StallF),
        .count_o (StallCount)
    );

    sat_counter32 u_flush_cnt (
        .clk_i   (clk),
        .rst_ni  (reset),
        .en_i    (flush_any),
        .count_o (FlushCount)
    );

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have these ports: clk  in  1  single clock, all state on rising edge.
REQ-002 reset  in  1  SHALL be an asynchronous, active-low reset (asserted at 0).
REQ-003 Rs1D, Rs2D, RdD  in  5 each  SHALL be the source and destination register fields of the instruction in Decode.
REQ-004 ResultSrcE0, PCSrcE, RegWriteM, RegWriteW  in  1 each  SHALL be the controller stage signals: load in Execute, redirect taken, and write-enables in Memory and Writeback.
REQ-005 DMemReadyM  in  1  SHALL be the data-memory ready signal; 0 means the Memory-stage access is not complete.
REQ-006 StallF, StallD, StallE, StallM  out  1 each  SHALL be the hold enables for the PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-007 FlushD, Flush_E, FlushW  out  1 each  SHALL be the bubble-insert signals for the IF/ID, ID/EX and MEM/WB registers.
REQ-008 ForwardAE, ForwardBE  out  2 each  SHALL select the ALU operand source: 00 register file, 10 ALUResultM, 01 ResultW.
REQ-009 StallCount, FlushCount  out  32 each  SHALL be saturating performance counters.
REQ-010 MemTimeout  out  1  SHALL be a sticky error flag.

Function
REQ-011 The block SHALL track Rs1E, Rs2E, RdE, RdM and RdW internally:
- ID->EX loads when StallE=0, and loads zeros when Flush_E=1.
- EX->MEM loads when StallM=0.
- MEM->WB loads RdM, or zero when FlushW=1.
REQ-012 Load-use SHALL be detected as lwStall = ResultSrcE0 & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-013 A memory wait SHALL be detected as memWait = !DMemReadyM.
REQ-014 When memWait=1, the block SHALL drive:
- StallF=StallD=StallE=StallM=1 and FlushW=1.
- FlushD=0 and Flush_E=0, so PCSrcE and the load-use condition are held, not acted on.
REQ-015 When memWait=0, the block SHALL drive:
- StallF=StallD=lwStall, StallE=StallM=0 and FlushW=0.
- FlushD=PCSrcE and Flush_E=lwStall|PCSrcE.
REQ-016 When a load-use and a redirect occur in the same cycle, the redirect SHALL win for D (FlushD=1), and Flush_E SHALL still be 1.
REQ-017 ForwardAE SHALL be:
- 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
- else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
- else 00.
ForwardBE SHALL use the same rule with Rs2E, and M priority over W.
REQ-018 All stall, flush and forward outputs SHALL be combinational from registered state plus the current inputs, with zero-cycle latency.
REQ-019 StallCount SHALL increment by 1 on each cycle with StallF=1 and saturate at 0xFFFFFFFF.
REQ-020 FlushCount SHALL increment by 1 on each cycle with FlushD|Flush_E=1 and saturate at 0xFFFFFFFF.
REQ-021 The block SHALL use a two-state FSM: RUN -> WAIT when memWait=1; WAIT -> RUN when DMemReadyM=1.
REQ-022 An 8-bit wait counter SHALL clear on entry to WAIT, increment each WAIT cycle, and clear in RUN.
REQ-023 MemTimeout SHALL set when the wait counter reaches 255 and stay set until reset; the stalls SHALL continue while MemTimeout is set.

Reset
REQ-024 While reset=0, the block SHALL drive Rs1E, Rs2E, RdE, RdM, RdW, both counters, the wait counter and MemTimeout to 0, with the FSM in RUN.
REQ-025 With reset=0 and all inputs at 0, the block SHALL output StallF/D/E/M=1, FlushW=1, FlushD=0, Flush_E=0, ForwardAE/BE=00 and StallCount/FlushCount=0.
REQ-026 Reset asserted mid-stall or mid-WAIT SHALL abandon the wait immediately, with no pending flush retained.

Structure
REQ-027 The forward select encodings (FWD_RF, FWD_M, FWD_W), the FSM state encodings and the timeout limit (255) SHALL reside in a shared package.
REQ-028 The block SHALL instantiate one sub-module, sat_counter32 (increment enable, saturating), twice for the performance counters.

Verification
REQ-029 Load-use: with lw x5 in E (ResultSrcE0=1, RdE=5) and Rs1D=5, the bench SHALL see StallF=StallD=Flush_E=1 for exactly one cycle, and StallCount increase by 1.
REQ-030 Forwarding: with RdM=RdW=7, both RegWrite=1 and Rs1E=Rs2E=7, the bench SHALL see ForwardAE=ForwardBE=10; with RegWriteM=0 it SHALL see 01; with Rd=0 it SHALL see 00.
REQ-031 Redirect and load-use together: with PCSrcE=1 while lwStall=1, the bench SHALL see FlushD=1, Flush_E=1, StallF=1 and FlushCount increase by 1.
REQ-032 Memory wait: with DMemReadyM=0 for 3 cycles during PCSrcE=1, the bench SHALL see all stalls=1, FlushW=1 and FlushD=0 for those 3 cycles, then FlushD=Flush_E=1 in the cycle DMemReadyM returns to 1.
REQ-033 Timeout: with DMemReadyM=0 held for 300 cycles, the bench SHALL see MemTimeout rise at the 255th WAIT cycle and remain 1 after ready returns, until reset=0.
REQ-034 Async reset: with reset driven to 0 mid-WAIT away from a clock edge, the bench SHALL see the counters, MemTimeout and the FSM clear immediately.
